// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo definitions: ALU opcode encodings, the "no producer" tag,
// default widths and the ALU sequencer state encoding.
package tomasulo_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_TAG_W  = 6;

  // A tag of zero means the operand value is already present.
  localparam int TAG_NONE = 0;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_AND = 3'b101;
  localparam logic [2:0] OP_NOT = 3'b110;
  localparam logic [2:0] OP_XOR = 3'b111;

  typedef enum logic [1:0] {
    ALU_IDLE = 2'd0,
    ALU_EXEC = 2'd1,
    ALU_DONE = 2'd2
  } alu_state_e;

endpackage

// File: rtl/rs_age_matrix.sv
// Age matrix for NUM_RS reservation stations.
// age_q[i][j] = 1 means station i was allocated before station j.
// Ports:
//   clock, reset_n : clock and asynchronous active-low reset
//   alloc_oh       : one-hot station allocated this cycle (becomes youngest)
//   free_oh        : stations released this cycle (all ones on flush)
//   req            : stations competing for selection
//   oldest_oh      : one-hot oldest requesting station (zero if no request)
module rs_age_matrix #(
  parameter int N = 3
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic [N-1:0] alloc_oh,
  input  logic [N-1:0] free_oh,
  input  logic [N-1:0] req,
  output logic [N-1:0] oldest_oh
);

  logic [N-1:0] age_q [N];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N; i++) age_q[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          if (free_oh[i] || free_oh[j]) age_q[i][j] <= 1'b0;
          // Every other station is older than the newcomer; the newcomer
          // is older than nobody. Writes after the free so alloc wins.
          if (alloc_oh[j] && (i != j)) age_q[i][j] <= 1'b1;
          if (alloc_oh[i]) age_q[i][j] <= 1'b0;
        end
      end
    end
  end

  // A requester wins when it is older than every other requester.
  always_comb begin
    oldest_oh = '0;
    for (int i = 0; i < N; i++) begin
      oldest_oh[i] = req[i];
      for (int j = 0; j < N; j++) begin
        if ((i != j) && req[j] && !age_q[i][j]) oldest_oh[i] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/rs_alu_bank.sv
// Integer-ALU reservation-station bank with one shared multi-cycle ALU.
// Stations are allocated lowest-free-first, snoop the CDB for pending
// operands, and dispatch oldest-ready-first to the ALU when it is idle.
// Ports:
//   clock, reset_n, flush : clock, async active-low reset, sync clear
//   issue_*               : allocation request from the issue stage
//   cdb_*                 : common data bus broadcast being snooped
//   res_*                 : result toward the CDB arbiter
//   rs_busy               : per-station busy flags
//   dbg_state             : ALU sequencer state (alu_state_e encoding)
// Handshakes: a transfer happens on the rising edge where valid and ready
// are both high. The sender holds payload stable while valid && !ready;
// issue_ready does not depend on issue_valid, res_valid does not depend
// on res_ready.
module rs_alu_bank
  import tomasulo_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TAG_W   = DEF_TAG_W,
  parameter int NUM_RS  = 3,
  parameter int RS_BASE = 1,
  parameter int LATENCY = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic [2:0]        issue_op,
  input  logic [DATA_W-1:0] issue_a,
  input  logic [DATA_W-1:0] issue_b,
  input  logic              issue_a_pend,
  input  logic              issue_b_pend,
  output logic [TAG_W-1:0]  issue_tag,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [TAG_W-1:0]  res_tag,
  output logic [DATA_W-1:0] res_data,
  output logic              res_err,
  output logic [NUM_RS-1:0] rs_busy,
  output logic [1:0]        dbg_state
);

  localparam int IDX_W = (NUM_RS > 1) ? $clog2(NUM_RS) : 1;
  localparam int CNT_W = 4;

  // Station storage
  logic [NUM_RS-1:0] busy_q, exec_q;
  logic [2:0]        op_q [NUM_RS];
  logic [DATA_W-1:0] vj_q [NUM_RS];
  logic [DATA_W-1:0] vk_q [NUM_RS];
  logic [TAG_W-1:0]  qj_q [NUM_RS];
  logic [TAG_W-1:0]  qk_q [NUM_RS];

  // ALU sequencer
  alu_state_e        state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              res_valid_q, res_err_q;
  logic [DATA_W-1:0] res_data_q;
  logic [TAG_W-1:0]  res_tag_q;
  logic [IDX_W-1:0]  res_idx_q;

  logic [IDX_W-1:0]  free_idx, disp_idx;
  logic              alloc, disp_go, hs, cdb_ok;
  logic [NUM_RS-1:0] alloc_oh, free_oh, req, oldest_oh;
  logic [DATA_W-1:0] in_vj, in_vk, alu_a, alu_b, alu_res;
  logic [TAG_W-1:0]  in_qj, in_qk, tag_a, tag_b;
  logic              alu_err;

  assign cdb_ok = cdb_valid && (cdb_tag != TAG_W'(TAG_NONE));

  // Lowest-index free station
  always_comb begin
    free_idx = '0;
    for (int i = NUM_RS - 1; i >= 0; i--) begin
      if (!busy_q[i]) free_idx = IDX_W'(i);
    end
  end

  assign issue_ready = ~&busy_q;
  assign issue_tag   = TAG_W'(RS_BASE) + TAG_W'(free_idx);
  assign alloc       = issue_valid && issue_ready && !flush;
  assign alloc_oh    = alloc ? (NUM_RS'(1) << free_idx) : '0;

  // Operand capture at issue, including a same-cycle CDB bypass
  always_comb begin
    tag_a = issue_a[TAG_W-1:0];
    tag_b = issue_b[TAG_W-1:0];
    in_vj = issue_a;
    in_qj = '0;
    in_vk = issue_b;
    in_qk = '0;
    if (issue_a_pend && (tag_a != TAG_W'(TAG_NONE))) begin
      if (cdb_ok && (cdb_tag == tag_a)) in_vj = cdb_data;
      else                              in_qj = tag_a;
    end
    // NOT has no second operand, so it never waits on B.
    if (issue_b_pend && (tag_b != TAG_W'(TAG_NONE)) && (issue_op != OP_NOT)) begin
      if (cdb_ok && (cdb_tag == tag_b)) in_vk = cdb_data;
      else                              in_qk = tag_b;
    end
  end

  // Dispatch candidates: busy, not yet executing, both operands present
  always_comb begin
    for (int i = 0; i < NUM_RS; i++) begin
      req[i] = busy_q[i] && !exec_q[i] &&
               (qj_q[i] == TAG_W'(TAG_NONE)) && (qk_q[i] == TAG_W'(TAG_NONE));
    end
  end

  always_comb begin
    disp_idx = '0;
    for (int i = 0; i < NUM_RS; i++) begin
      if (oldest_oh[i]) disp_idx = IDX_W'(i);
    end
  end

  assign disp_go = (state_q == ALU_IDLE) && (|oldest_oh) && !flush;
  assign hs      = (state_q == ALU_DONE) && res_ready && !flush;
  assign free_oh = flush ? '1 : (hs ? (NUM_RS'(1) << res_idx_q) : '0);

  rs_age_matrix #(.N(NUM_RS)) u_age (
    .clock     (clock),
    .reset_n   (reset_n),
    .alloc_oh  (alloc_oh),
    .free_oh   (free_oh),
    .req       (req),
    .oldest_oh (oldest_oh)
  );

  // ALU function; the result is captured at dispatch and released when
  // the latency counter expires.
  always_comb begin
    alu_a   = vj_q[disp_idx];
    alu_b   = vk_q[disp_idx];
    alu_err = 1'b0;
    alu_res = '0;
    case (op_q[disp_idx])
      OP_ADD:  alu_res = alu_a + alu_b;
      OP_SUB:  alu_res = alu_a - alu_b;
      OP_OR:   alu_res = alu_a | alu_b;
      OP_AND:  alu_res = alu_a & alu_b;
      OP_NOT:  alu_res = ~alu_a;
      OP_XOR:  alu_res = alu_a ^ alu_b;
      default: alu_err = 1'b1;
    endcase
  end

  // Station state
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      busy_q <= '0;
      exec_q <= '0;
      for (int i = 0; i < NUM_RS; i++) begin
        op_q[i] <= '0;
        vj_q[i] <= '0;
        vk_q[i] <= '0;
        qj_q[i] <= '0;
        qk_q[i] <= '0;
      end
    end else if (flush) begin
      busy_q <= '0;
      exec_q <= '0;
    end else begin
      for (int i = 0; i < NUM_RS; i++) begin
        if (busy_q[i] && cdb_ok && (qj_q[i] == cdb_tag)) begin
          vj_q[i] <= cdb_data;
          qj_q[i] <= '0;
        end
        if (busy_q[i] && cdb_ok && (qk_q[i] == cdb_tag)) begin
          vk_q[i] <= cdb_data;
          qk_q[i] <= '0;
        end
      end
      if (alloc) begin
        busy_q[free_idx] <= 1'b1;
        exec_q[free_idx] <= 1'b0;
        op_q[free_idx]   <= issue_op;
        vj_q[free_idx]   <= in_vj;
        vk_q[free_idx]   <= in_vk;
        qj_q[free_idx]   <= in_qj;
        qk_q[free_idx]   <= in_qk;
      end
      if (disp_go) exec_q[disp_idx] <= 1'b1;
      if (hs) begin
        busy_q[res_idx_q] <= 1'b0;
        exec_q[res_idx_q] <= 1'b0;
      end
    end
  end

  // ALU sequencer: IDLE -> EXEC (LATENCY cycles) -> DONE -> IDLE on grant
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ALU_IDLE;
      cnt_q       <= '0;
      res_valid_q <= 1'b0;
      res_err_q   <= 1'b0;
      res_data_q  <= '0;
      res_tag_q   <= '0;
      res_idx_q   <= '0;
    end else if (flush) begin
      state_q     <= ALU_IDLE;
      cnt_q       <= '0;
      res_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ALU_IDLE: begin
          if (disp_go) begin
            state_q    <= ALU_EXEC;
            cnt_q      <= CNT_W'(LATENCY - 1);
            res_data_q <= alu_res;
            res_err_q  <= alu_err;
            res_tag_q  <= TAG_W'(RS_BASE) + TAG_W'(disp_idx);
            res_idx_q  <= disp_idx;
          end
        end
        ALU_EXEC: begin
          if (cnt_q == '0) begin
            state_q     <= ALU_DONE;
            res_valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ALU_DONE: begin
          if (res_ready) begin
            state_q     <= ALU_IDLE;
            res_valid_q <= 1'b0;
          end
        end
        default: state_q <= ALU_IDLE;
      endcase
    end
  end

  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_err   = res_err_q;
  assign res_tag   = res_tag_q;
  assign rs_busy   = busy_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_rs_alu_bank.sv
module tb_rs_alu_bank;

  localparam int DW   = 32;
  localparam int TW   = 6;
  localparam int NRS  = 3;
  localparam int BASE = 1;
  localparam int LAT  = 2;
  localparam int EW   = DW + TW + 1;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          flush = 1'b0;
  logic          issue_valid = 1'b0;
  logic          issue_ready;
  logic [2:0]    issue_op = '0;
  logic [DW-1:0] issue_a = '0, issue_b = '0;
  logic          issue_a_pend = 1'b0, issue_b_pend = 1'b0;
  logic [TW-1:0] issue_tag;
  logic          cdb_valid = 1'b0;
  logic [TW-1:0] cdb_tag = '0;
  logic [DW-1:0] cdb_data = '0;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic [TW-1:0] res_tag;
  logic [DW-1:0] res_data;
  logic          res_err;
  logic [NRS-1:0] rs_busy;
  logic [1:0]    dbg_state;

  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q[$];

  rs_alu_bank #(.DATA_W(DW), .TAG_W(TW), .NUM_RS(NRS), .RS_BASE(BASE), .LATENCY(LAT)) dut (
    .clock(clock), .reset_n(reset_n), .flush(flush),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_op(issue_op),
    .issue_a(issue_a), .issue_b(issue_b), .issue_a_pend(issue_a_pend),
    .issue_b_pend(issue_b_pend), .issue_tag(issue_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_tag(res_tag),
    .res_data(res_data), .res_err(res_err), .rs_busy(rs_busy), .dbg_state(dbg_state)
  );

  // Clock / reset
  always #5 clock = ~clock;

  // Outputs are sampled 1 time unit after the rising edge.
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) cyc();
    reset_n = 1'b1;
    cyc();
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference ALU: {err, data}
  function automatic logic [DW:0] ref_alu(input logic [2:0] op, input logic [DW-1:0] a,
                                          input logic [DW-1:0] b);
    case (op)
      3'b000:  return {1'b0, a + b};
      3'b001:  return {1'b0, a - b};
      3'b100:  return {1'b0, a | b};
      3'b101:  return {1'b0, a & b};
      3'b110:  return {1'b0, ~a};
      3'b111:  return {1'b0, a ^ b};
      default: return {1'b1, {DW{1'b0}}};
    endcase
  endfunction

  // Drivers
  task automatic issue(input logic [2:0] op, input logic [DW-1:0] a, input logic ap,
                       input logic [DW-1:0] b, input logic bp);
    issue_valid = 1'b1; issue_op = op;
    issue_a = a; issue_a_pend = ap; issue_b = b; issue_b_pend = bp;
    cyc();
    issue_valid = 1'b0; issue_a_pend = 1'b0; issue_b_pend = 1'b0;
  endtask

  task automatic bcast(input logic [TW-1:0] t, input logic [DW-1:0] d);
    cdb_valid = 1'b1; cdb_tag = t; cdb_data = d;
    cyc();
    cdb_valid = 1'b0;
  endtask

  task automatic wait_res(input int limit);
    bit ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (res_valid) begin ok = 1'b1; break; end
      cyc();
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL wait_res: res_valid stayed 0 for %0d cycles, expected 1", limit);
    end
  endtask

  task automatic grant();
    res_ready = 1'b1;
    cyc();
    res_ready = 1'b0;
  endtask

  task automatic expect_res(input string name, input logic [TW-1:0] t,
                            input logic [DW-1:0] d, input logic e);
    wait_res(4 * (LAT + 2));
    chk({name, "_tag"}, res_tag, t);
    chk({name, "_data"}, res_data, d);
    chk({name, "_err"}, res_err, e);
  endtask

  typedef struct {
    logic [2:0]    op;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic          b_pend;
    logic [DW-1:0] exp_data;
    logic          exp_err;
  } vec_t;

  vec_t vecs[10];

  logic [NRS-1:0] m_busy;
  int stall;

  initial begin
    vecs[0] = '{3'b000, 32'h7FFF_FFFF, 32'h1,         1'b0, 32'h8000_0000, 1'b0};
    vecs[1] = '{3'b000, 32'hFFFF_FFFF, 32'h1,         1'b0, 32'h0000_0000, 1'b0};
    vecs[2] = '{3'b001, 32'h5,         32'h7,         1'b0, 32'hFFFF_FFFE, 1'b0};
    vecs[3] = '{3'b100, 32'hF0F0_0000, 32'h0000_0F0F, 1'b0, 32'hF0F0_0F0F, 1'b0};
    vecs[4] = '{3'b101, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0, 32'h0F00_0F00, 1'b0};
    vecs[5] = '{3'b110, 32'h0F0F_0F0F, 32'h9,         1'b1, 32'hF0F0_F0F0, 1'b0};
    vecs[6] = '{3'b111, 32'hAAAA_5555, 32'hFFFF_0000, 1'b0, 32'h5555_5555, 1'b0};
    vecs[7] = '{3'b010, 32'h1234,      32'h1,         1'b0, 32'h0,         1'b1};
    vecs[8] = '{3'b011, 32'h1234,      32'h1,         1'b0, 32'h0,         1'b1};
    vecs[9] = '{3'b001, 32'h0,         32'h1,         1'b0, 32'hFFFF_FFFF, 1'b0};

    // Reset state
    do_reset();
    chk("rst_ready", issue_ready, 1);
    chk("rst_tag", issue_tag, BASE);
    chk("rst_busy", rs_busy, 0);
    chk("rst_valid", res_valid, 0);
    chk("rst_data", res_data, 0);
    chk("rst_res_tag", res_tag, 0);
    chk("rst_err", res_err, 0);

    // Basic add with exact latency
    chk("add_tag", issue_tag, 1);
    issue(3'b000, 32'd5, 1'b0, 32'd7, 1'b0);
    chk("add_busy", rs_busy, 3'b001);
    cyc();
    chk("add_exec_state", dbg_state, 1);
    cyc();
    chk("add_valid_early", res_valid, 0);
    cyc();
    chk("add_valid", res_valid, 1);
    chk("add_data", res_data, 12);
    chk("add_res_tag", res_tag, 1);
    grant();
    chk("add_freed", rs_busy, 0);
    chk("add_valid_clr", res_valid, 0);

    // All stations pending; CDB releases the middle one first
    chk("fill_tag1", issue_tag, 1);
    issue(3'b000, 32'd9, 1'b1, 32'd1, 1'b0);
    chk("fill_tag2", issue_tag, 2);
    issue(3'b000, 32'd10, 1'b1, 32'd1, 1'b0);
    chk("fill_tag3", issue_tag, 3);
    issue(3'b000, 32'd11, 1'b1, 32'd1, 1'b0);
    chk("full_ready", issue_ready, 0);
    chk("full_busy", rs_busy, 3'b111);
    issue(3'b000, 32'd1, 1'b0, 32'd1, 1'b0);   // ignored while full
    chk("full_no_dispatch", dbg_state, 0);
    bcast(6'd10, 32'd3);
    expect_res("snoop2", 6'd2, 32'd4, 1'b0);
    grant();
    chk("snoop2_busy", rs_busy, 3'b101);
    repeat (LAT + 3) cyc();
    chk("waiting_idle", res_valid, 0);
    bcast(6'd11, 32'd100);
    expect_res("snoop3", 6'd3, 32'd101, 1'b0);
    grant();
    bcast(6'd9, 32'd200);
    expect_res("snoop1", 6'd1, 32'd201, 1'b0);
    grant();
    chk("fill_empty", rs_busy, 0);

    // Bypass at issue
    cdb_valid = 1'b1; cdb_tag = 6'd9; cdb_data = 32'd20;
    issue(3'b001, 32'd9, 1'b1, 32'd5, 1'b0);
    cdb_valid = 1'b0;
    expect_res("bypass", 6'd1, 32'd15, 1'b0);
    grant();

    // Age order: station 2 is older than a re-allocated station 1
    issue(3'b000, 32'd1, 1'b0, 32'd1, 1'b0);
    issue(3'b000, 32'd20, 1'b1, 32'd10, 1'b0);
    expect_res("age_pre", 6'd1, 32'd2, 1'b0);
    grant();
    chk("age_realloc_tag", issue_tag, 1);
    issue(3'b000, 32'd20, 1'b1, 32'd1000, 1'b0);
    bcast(6'd20, 32'd5);
    expect_res("age_old", 6'd2, 32'd15, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("stall_valid", res_valid, 1);
      chk("stall_data", res_data, 15);
      chk("stall_tag", res_tag, 2);
      chk("stall_busy", rs_busy, 3'b011);
    end
    grant();
    expect_res("age_young", 6'd1, 32'd1005, 1'b0);
    grant();

    // Flush during EXEC with a concurrent issue
    issue(3'b000, 32'd2, 1'b0, 32'd3, 1'b0);
    cyc();
    flush = 1'b1; issue_valid = 1'b1; issue_op = 3'b000; issue_a = 32'd4; issue_b = 32'd4;
    cyc();
    flush = 1'b0; issue_valid = 1'b0;
    chk("flush_busy", rs_busy, 0);
    chk("flush_valid", res_valid, 0);
    chk("flush_state", dbg_state, 0);
    chk("flush_ready", issue_ready, 1);
    repeat (LAT + 3) cyc();
    chk("flush_no_result", res_valid, 0);
    chk("flush_no_alloc", rs_busy, 0);

    // Asynchronous reset mid-EXEC
    issue(3'b000, 32'd2, 1'b0, 32'd3, 1'b0);
    cyc();
    #2 reset_n = 1'b0;
    #1;
    chk("areset_busy", rs_busy, 0);
    chk("areset_state", dbg_state, 0);
    chk("areset_ready", issue_ready, 1);
    cyc();
    reset_n = 1'b1;
    cyc();

    // Table-driven single operations
    foreach (vecs[k]) begin
      chk("vec_issue_tag", issue_tag, 1);
      issue(vecs[k].op, vecs[k].a, 1'b0, vecs[k].b, vecs[k].b_pend);
      expect_res($sformatf("vec%0d", k), 6'd1, vecs[k].exp_data, vecs[k].exp_err);
      grant();
      chk("vec_freed", rs_busy, 0);
    end

    // Random traffic against the allocation/order model
    do_reset();
    m_busy = '0;
    stall = 0;
    for (int c = 0; c < 600; c++) begin
      bit iv, rr, free_any, hs;
      int lo;
      logic [2:0] op;
      logic [DW-1:0] a, b;
      logic [EW-1:0] e;
      logic [DW:0] r;

      if (res_valid) begin
        stall = 0;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL rand_spurious: res_valid 1 with no expected result, expected 0");
        end
      end else if (exp_q.size() > 0) begin
        stall++;
        if (stall > 3 * (LAT + 2) + 4) begin
          checks++; errors++;
          $display("FAIL rand_timeout: res_valid 0 for %0d cycles, expected 1", stall);
          break;
        end
      end

      iv = ($urandom_range(0, 1) == 1);
      rr = ($urandom_range(0, 2) != 0);
      op = 3'($urandom_range(0, 7));
      a = $urandom();
      b = $urandom();
      issue_valid = iv; issue_op = op; issue_a = a; issue_b = b;
      issue_a_pend = 1'b0; issue_b_pend = 1'b0;
      res_ready = rr;
      cdb_valid = ($urandom_range(0, 3) == 0);
      cdb_tag = 6'($urandom_range(40, 60));
      cdb_data = $urandom();

      free_any = 1'b0;
      lo = 0;
      for (int i = NRS - 1; i >= 0; i--) if (!m_busy[i]) begin free_any = 1'b1; lo = i; end
      chk("rand_ready", issue_ready, free_any);
      if (free_any) chk("rand_tag", issue_tag, BASE + lo);

      hs = res_valid && rr;
      if (hs && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("rand_res_err", res_err, e[EW-1]);
        chk("rand_res_tag", res_tag, e[DW+TW-1:DW]);
        chk("rand_res_data", res_data, e[DW-1:0]);
        m_busy[int'(e[DW+TW-1:DW]) - BASE] = 1'b0;
      end
      if (iv && free_any) begin
        r = ref_alu(op, a, b);
        m_busy[lo] = 1'b1;
        exp_q.push_back({r[DW], TW'(BASE + lo), r[DW-1:0]});
      end
      cyc();
      chk("rand_busy", rs_busy, m_busy);
    end
    issue_valid = 1'b0; cdb_valid = 1'b0; res_ready = 1'b1;
    for (int c = 0; c < 100 && exp_q.size() > 0; c++) begin
      logic [EW-1:0] e;
      if (res_valid) begin
        e = exp_q.pop_front();
        chk("drain_tag", res_tag, e[DW+TW-1:DW]);
        chk("drain_data", res_data, e[DW-1:0]);
      end
      cyc();
    end
    chk("drain_left", exp_q.size(), 0);
    res_ready = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rs_alu_bank.md
# rs_alu_bank

Parametrised integer-ALU reservation-station bank for the Tomasulo core: NUM_RS stations, one shared multi-cycle ALU, oldest-ready-first dispatch, and a valid/ready result handshake toward the CDB arbiter. It sits between the issue stage and the CDB. Operand tags are snooped from the CDB, including a same-cycle bypass at issue. Synchronous flush and asynchronous reset are supported.

## Interface
- DATA_W, 32, operand/result width
- TAG_W, 6, CDB tag width; tag 0 = "no producer / value valid"
- NUM_RS, 3, number of stations (2..8)
- RS_BASE, 1, tag of station 0; station i owns tag RS_BASE+i (nonzero, distinct)
- LATENCY, 2, ALU cycles from dispatch to result (1..8)

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous clear of all stations and the in-flight op
- issue_valid  in  1  issue request
- issue_ready  out  1  at least one station free
- issue_op  in  3  000 add, 001 sub, 100 or, 101 and, 110 not, 111 xor
- issue_a, issue_b  in  DATA_W  operand value, or tag in [TAG_W-1:0] when pending
- issue_a_pend, issue_b_pend  in  1  operand is a tag
- issue_tag  out  TAG_W  tag of allocated station, valid with the handshake
- cdb_valid  in  1  CDB broadcast this cycle
- cdb_tag  in  TAG_W  broadcast source
- cdb_data  in  DATA_W  broadcast value
- res_valid  out  1  result awaiting CDB grant
- res_ready  in  1  CDB grant
- res_tag  out  TAG_W  producing station tag
- res_data  out  DATA_W  result
- res_err  out  1  result produced from an illegal opcode
- rs_busy  out  NUM_RS  per-station busy

## Operation
- Issue: issue_valid && issue_ready allocates the lowest-index free station. The station records op, Vj/Qj, Vk/Qk and becomes youngest in age order. issue_tag is combinational from the free-station selection.
- Issue bypass: if a pending tag equals cdb_tag while cdb_valid is high in the issue cycle, the station captures cdb_data and sets Q=0.
- NOT: forces Qk=0; B is ignored.
- Snoop: each cycle, every busy station with Qj or Qk equal to cdb_tag (cdb_valid=1, tag≠0) latches cdb_data. Both operands may capture on the same edge, and all stations capture in parallel.
- Dispatch: only when the ALU is idle (no op in flight, no result pending). Selects the oldest busy, not-executing station with Qj=Qk=0. The station stays busy and is marked executing.
- ALU arithmetic: wraps modulo 2^DATA_W. Opcodes 010/011 produce res_data=0 with res_err=1.
- Result: held stable while res_valid && !res_ready. On the handshake edge, the station is freed, its age entry cleared, and the ALU goes idle.
- ALU state machine: IDLE → EXEC (dispatch, counter=LATENCY-1) → EXEC until counter=0 → DONE (res_valid=1) → IDLE on handshake.
- flush: clears all busy, executing, res_valid and the FSM on the next edge. If flush and issue occur in the same cycle, flush wins and nothing is allocated.
- reset_n low: immediate clear. All outputs read 0 except issue_ready=1 and issue_tag=RS_BASE.

## Timing
- Issue at edge T with both operands ready → dispatch at edge T+1 → res_valid high after edge T+1+LATENCY.
- Operand arriving by CDB at edge T → station eligible for dispatch at edge T+1.
- A station freed at edge T is reusable by an issue at edge T+1; there is no same-cycle reuse.
- issue_ready=0 when all stations are busy. Issue requests are ignored while issue_ready=0.
- Next dispatch is earliest the edge after a handshake, so peak throughput is one result per LATENCY+2 cycles.

## Structure
- Shared package `tomasulo_pkg`: ALU opcode constants, TAG_NONE=0, tag/data width defaults.
- Sub-module `rs_age_matrix`: NUM_RS×NUM_RS age bits. Inputs are alloc one-hot, free one-hot and request mask; the output is the oldest-request one-hot.

## Test plan
- Reset then issue add 5+7, both operands ready → issue_tag=1. Dispatch the next cycle. After LATENCY cycles, res_valid with res_data=12, res_tag=1. res_ready=1 frees the station.
- Stations 1–3 filled with pending tags 9, 10, 11 → issue_ready=0. CDB broadcasts tag 10 (data 3) → station 2 captures and dispatches first; stations 1 and 3 stay waiting.
- Issue sub with A pending on tag 9 while cdb_valid, cdb_tag=9, cdb_data=20, B=5 → bypass capture; result 15.
- Two stations become ready in the same cycle → the older one is dispatched first. res_ready held low for 4 cycles → res_data/res_tag stay stable and no second dispatch occurs.
- Opcode 011 issued → res_err=1, res_data=0. Add 0x7FFFFFFF+1 → 0x80000000 (wrap).
- flush asserted during EXEC and during a concurrent issue → all rs_busy=0, res_valid=0 and no allocation. Driving reset_n low mid-EXEC clears all state asynchronously.
